// File: rtl/alu_slice_sequencer_pkg.sv
// Shared types and constants for the 2-bit ALU slice sequencer.
// Optional status capture is enabled with the ALU_SEQ_STATUS_EN macro.
package alu_seq_pkg;

  localparam int SLICE_W = 2;
  localparam int FUNC_W  = 4;
  localparam int ST_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of 2-bit slices needed to cover a WIDTH-bit operand
  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

  // Slice counter width, never narrower than one bit
  function automatic int calc_cw(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// Request, slice-drive and response signals of the ALU slice sequencer.
// The slave modport is the sequencer view, the master modport is the
// view of whoever issues requests, hosts the slice and takes responses.
// rsp_status only exists when ALU_SEQ_STATUS_EN is defined.
interface alu_slice_sequencer_if #(
  parameter int WIDTH = 16
);
  import alu_seq_pkg::*;

  localparam int NSLICE = calc_nslice(WIDTH);

  logic                 req_valid;
  logic                 req_ready;
  logic [WIDTH-1:0]     req_a;
  logic [WIDTH-1:0]     req_b;
  logic [FUNC_W-1:0]    req_func;
  logic                 req_mode;
  logic                 req_cin;

  logic [SLICE_W-1:0]   alu_a;
  logic [SLICE_W-1:0]   alu_b;
  logic [FUNC_W-1:0]    alu_func;
  logic                 alu_mode;
  logic                 alu_cin;
  logic [SLICE_W-1:0]   alu_r;
  logic                 alu_cout;
  logic [ST_W-1:0]      alu_st;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH-1:0]     rsp_result;
  logic                 rsp_cout;
  logic                 rsp_zero;
`ifdef ALU_SEQ_STATUS_EN
  logic [ST_W*NSLICE-1:0] rsp_status;
`endif

  modport slave (
`ifdef ALU_SEQ_STATUS_EN
    output rsp_status,
`endif
    input  req_valid, req_a, req_b, req_func, req_mode, req_cin,
    output req_ready,
    output alu_a, alu_b, alu_func, alu_mode, alu_cin,
    input  alu_r, alu_cout, alu_st,
    output rsp_valid, rsp_result, rsp_cout, rsp_zero,
    input  rsp_ready
  );

  modport master (
`ifdef ALU_SEQ_STATUS_EN
    input  rsp_status,
`endif
    output req_valid, req_a, req_b, req_func, req_mode, req_cin,
    input  req_ready,
    input  alu_a, alu_b, alu_func, alu_mode, alu_cin,
    output alu_r, alu_cout, alu_st,
    input  rsp_valid, rsp_result, rsp_cout, rsp_zero,
    output rsp_ready
  );

endinterface

// File: rtl/alu_slice_sequencer.sv
// Drives a WIDTH-bit operation through an external 2-bit ALU slice, one
// slice per cycle LSB first, rippling the slice carry between cycles and
// assembling the full result, carry-out and zero flag.
// Defining ALU_SEQ_STATUS_EN additionally collects the per-slice status
// bits into rsp_status.
module alu_slice_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  alu_slice_sequencer_if.slave bus
);

  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int CW     = calc_cw(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  logic              last_slice;
  logic              run;
  logic              done;

  logic [WIDTH-1:0]  opa_q;
  logic [WIDTH-1:0]  opb_q;
  logic [WIDTH-1:0]  res_q;
  logic [WIDTH-1:0]  res_next;
  logic [FUNC_W-1:0] func_q;
  logic              mode_q;
  logic              cin_q;
  logic [CW-1:0]     count_q;
  logic              cout_q;
  logic              zero_q;

`ifdef ALU_SEQ_STATUS_EN
  logic [ST_W*NSLICE-1:0] status_q;
  logic [ST_W*NSLICE-1:0] status_next;
`endif

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode plus the accept / last-slice strobes used by the datapath
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    last_slice = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (count_q == LAST) begin
          last_slice = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result shifts right so the slice written last (the MSB slice) enters at the top
  always_comb begin
    res_next = res_q >> SLICE_W;
    res_next[WIDTH-1 -: SLICE_W] = bus.alu_r;
  end

`ifdef ALU_SEQ_STATUS_EN
  // Status groups shift in the same way, leaving slice 0 in the low group
  always_comb begin
    status_next = status_q >> ST_W;
    status_next[ST_W*NSLICE-1 -: ST_W] = bus.alu_st;
  end
`endif

  // Operand latch, operand shifting, carry ripple and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      func_q   <= '0;
      mode_q   <= 1'b0;
      cin_q    <= 1'b0;
      count_q  <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ALU_SEQ_STATUS_EN
      status_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            opa_q    <= bus.req_a;
            opb_q    <= bus.req_b;
            func_q   <= bus.req_func;
            mode_q   <= bus.req_mode;
            cin_q    <= bus.req_cin;
            count_q  <= '0;
            res_q    <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ALU_SEQ_STATUS_EN
            status_q <= '0;
`endif
          end
        end
        RUN: begin
          opa_q    <= opa_q >> SLICE_W;
          opb_q    <= opb_q >> SLICE_W;
          cin_q    <= bus.alu_cout;
          res_q    <= res_next;
          count_q  <= count_q + CW'(1);
`ifdef ALU_SEQ_STATUS_EN
          status_q <= status_next;
`endif
          if (last_slice) begin
            cout_q <= bus.alu_cout;
            zero_q <= (res_next == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign run  = (state_q == RUN);
  assign done = (state_q == DONE);

  assign bus.req_ready  = (state_q == IDLE) && !rst;

  assign bus.alu_a      = run ? opa_q[SLICE_W-1:0] : '0;
  assign bus.alu_b      = run ? opb_q[SLICE_W-1:0] : '0;
  assign bus.alu_func   = run ? func_q : '0;
  assign bus.alu_mode   = run & mode_q;
  assign bus.alu_cin    = run & cin_q;

  assign bus.rsp_valid  = done;
  assign bus.rsp_result = done ? res_q : '0;
  assign bus.rsp_cout   = done & cout_q;
  assign bus.rsp_zero   = done & zero_q;
`ifdef ALU_SEQ_STATUS_EN
  assign bus.rsp_status = done ? status_q : '0;
`endif

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Self-checking bench for alu_slice_sequencer with a behavioural 2-bit slice
// stub. Expected responses are queued when a request is issued and compared
// when rsp_valid rises. Status groups are compared when ALU_SEQ_STATUS_EN is set.
module tb_alu_slice_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 2;
  localparam int PERIOD = 10;

  typedef struct {
    logic [WIDTH-1:0]       result;
    logic                   cout;
    logic                   zero;
    logic [3*NSLICE-1:0]    status;
    time                    acceptTime;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_slice_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_slice_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #(PERIOD / 2) clk = ~clk;

  exp_t sbQueue[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;
  logic prevValid = 1'b0;
  logic [2:0] stubSum;

  // Behavioural slice: add in arithmetic mode, xor with carry pass-through in logic mode
  always_comb begin
    stubSum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {2'b00, bus.alu_cin};
    if (bus.alu_mode) begin
      bus.alu_r    = stubSum[1:0];
      bus.alu_cout = stubSum[2];
    end else begin
      bus.alu_r    = bus.alu_a ^ bus.alu_b;
      bus.alu_cout = bus.alu_cin;
    end
    bus.alu_st = {bus.alu_a[1], bus.alu_b[1], bus.alu_a[0]};
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Full-width reference for what the chained slices should produce
  function automatic exp_t modelOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic mode, input logic cin);
    exp_t e;
    logic [WIDTH:0] s;
    if (mode) begin
      s        = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      e.result = s[WIDTH-1:0];
      e.cout   = s[WIDTH];
    end else begin
      e.result = a ^ b;
      e.cout   = cin;
    end
    e.zero = (e.result == '0);
    for (int k = 0; k < NSLICE; k++)
      e.status[3*k +: 3] = {a[2*k+1], b[2*k+1], a[2*k]};
    e.acceptTime = 0;
    return e;
  endfunction

  // Issues one request from a negedge; returns at the negedge of slice 0
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [3:0] func, input logic mode, input logic cin,
                               input bit expectRsp);
    exp_t e;
    int   n = 0;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_func  = func;
    bus.req_mode  = mode;
    bus.req_cin   = cin;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
    end else begin
      e = modelOp(a, b, mode, cin);
      e.acceptTime = $time;
      if (expectRsp) sbQueue.push_back(e);
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drainScoreboard();
    int n = 0;
    while (sbQueue.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbQueue.size() != 0) checkOutput("drain_timeout", 64'(sbQueue.size()), 64'd0);
    @(negedge clk);
  endtask

  // Response monitor: compares each newly presented response against the queue head
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
    end else begin
      if (bus.rsp_valid && !prevValid) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          monExp = sbQueue.pop_front();
          checkOutput("rsp_result", 64'(bus.rsp_result), 64'(monExp.result));
          checkOutput("rsp_cout", 64'(bus.rsp_cout), 64'(monExp.cout));
          checkOutput("rsp_zero", 64'(bus.rsp_zero), 64'(monExp.zero));
          checkOutput("rsp_latency", 64'(($time - monExp.acceptTime) / PERIOD),
                      64'(NSLICE + 1));
`ifdef ALU_SEQ_STATUS_EN
          checkOutput("rsp_status", 64'(bus.rsp_status), 64'(monExp.status));
`endif
        end
      end
      prevValid = bus.rsp_valid;
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #(PERIOD * 20000);
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence followed by a few random operations
  initial begin
    logic sawValid;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_func  = '0;
    bus.req_mode  = 1'b0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b1;
    rst           = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("reset_rsp_result", 64'(bus.rsp_result), 64'd0);
    checkOutput("reset_rsp_flags", 64'({bus.rsp_cout, bus.rsp_zero}), 64'd0);
    checkOutput("reset_alu_out",
                64'({bus.alu_a, bus.alu_b, bus.alu_func, bus.alu_mode, bus.alu_cin}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_req_ready", 64'(bus.req_ready), 64'd1);

    $display("[TB] carry across slice boundary");
    applyStimulus(16'h00FF, 16'h0001, 4'h3, 1'b1, 1'b0, 1'b1);
    drainScoreboard();

    $display("[TB] full ripple to carry-out");
    applyStimulus(16'hFFFF, 16'h0001, 4'h3, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < NSLICE; k++) begin
      checkOutput($sformatf("alu_cin_s%0d", k), 64'(bus.alu_cin), (k == 0) ? 64'd0 : 64'd1);
      @(negedge clk);
    end
    drainScoreboard();

    $display("[TB] logic mode and func hold");
    checkOutput("alu_func_idle", 64'(bus.alu_func), 64'd0);
    applyStimulus(16'h1234, 16'h1234, 4'hA, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < NSLICE; k++) begin
      checkOutput("alu_func_run", 64'(bus.alu_func), 64'hA);
      @(negedge clk);
    end
    checkOutput("alu_func_done", 64'(bus.alu_func), 64'd0);
    drainScoreboard();

    $display("[TB] response backpressure");
    bus.rsp_ready = 1'b0;
    applyStimulus(16'h0005, 16'h0003, 4'h1, 1'b1, 1'b0, 1'b1);
    repeat (NSLICE) @(negedge clk);
    bus.req_a     = 16'hFFFF;
    bus.req_b     = 16'hFFFF;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      checkOutput("hold_rsp_result", 64'(bus.rsp_result), 64'h0008);
      checkOutput("hold_req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_req_ready", 64'(bus.req_ready), 64'd1);
    checkOutput("release_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    applyStimulus(16'h0102, 16'h0304, 4'h1, 1'b1, 1'b1, 1'b1);
    drainScoreboard();

    $display("[TB] reset during run");
    applyStimulus(16'h5555, 16'h1111, 4'h2, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("abort_alu_out", 64'({bus.alu_a, bus.alu_b, bus.alu_func}), 64'd0);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < NSLICE + 3; i++) begin
      @(negedge clk);
      sawValid = sawValid | bus.rsp_valid;
    end
    checkOutput("abort_no_rsp", 64'(sawValid), 64'd0);
    applyStimulus(16'h0001, 16'h0001, 4'h3, 1'b1, 1'b0, 1'b1);
    drainScoreboard();

    $display("[TB] status capture pattern");
    applyStimulus(16'h0003, 16'h0000, 4'h3, 1'b1, 1'b0, 1'b1);
    drainScoreboard();

    $display("[TB] random operations");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      drainScoreboard();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
